clock_display_scanner: RTL

Display-side reader for the chess-clock timer: takes the four BCD digits and OVERFLOW flag produced by the timer and drives a 4-digit, common-anode, multiplexed 7-segment display. Digits are snapshotted once per scan frame to prevent tearing, and the block adds leading-zero blanking, a blinking minutes/seconds separator and a blinking overflow indication. It sits between the timer and the board pins.

---
 rtl/clock_display_scanner_pkg.sv | 65 ++++++
 rtl/clock_display_scanner_bcd_to_seg.sv | 33 +++
 rtl/clock_display_scanner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clock_display_scanner_pkg.sv
// clock_display_scanner_pkg
//   Shared definitions for the chess-clock display path: active-low
//   7-segment patterns ({g,f,e,d,c,b,a}), the scan digit indices, the
//   snapshot record latched once per frame, and small helpers for walking
//   and decoding the scan index.
package clock_display_scanner_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan position; IDX_SU is the rightmost digit (AN[0])
  typedef enum logic [1:0] {
    IDX_SU = 2'd0,
    IDX_ST = 2'd1,
    IDX_MU = 2'd2,
    IDX_MT = 2'd3
  } digitIdx_e;

  // One frame's worth of displayed content
  typedef struct packed {
    logic [3:0] minTens;
    logic [3:0] minUnits;
    logic [3:0] secTens;
    logic [3:0] secUnits;
    logic       overflow;
  } shadow_t;

  // Scan order wraps from the leftmost digit back to the rightmost
  function automatic digitIdx_e nextIdx(input digitIdx_e idx);
    digitIdx_e result;
    result = IDX_SU;
    case (idx)
      IDX_SU:  result = IDX_ST;
      IDX_ST:  result = IDX_MU;
      IDX_MU:  result = IDX_MT;
      default: result = IDX_SU;
    endcase
    return result;
  endfunction

  // Active-low one-cold anode pattern for a scan position
  function automatic logic [3:0] anodeFor(input digitIdx_e idx);
    logic [3:0] result;
    result = 4'b1111;
    case (idx)
      IDX_SU:  result = 4'b1110;
      IDX_ST:  result = 4'b1101;
      IDX_MU:  result = 4'b1011;
      default: result = 4'b0111;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/clock_display_scanner_bcd_to_seg.sv
// bcd_to_seg
//   Combinational BCD to active-low 7-segment decoder. Codes 10..15 are
//   not valid BCD and are shown as a lone dash so a corrupted digit is
//   visible on the display instead of looking like a real number.
// Ports:
//   bcd_i  4-bit digit code
//   seg_o  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
  import clock_display_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; everything above 9 falls into the dash
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scanner.sv
// clock_display_scanner
//   Drives a 4-digit common-anode multiplexed 7-segment display from the
//   chess-clock timer's BCD digits. Content is snapshotted at every frame
//   boundary so a digit never changes partway through a scan, leading
//   minutes-tens zero is blanked, the separator DP blinks, and an expired
//   timer blinks the whole display with a steady DP.
// Parameters:
//   SCAN_DIV      clock cycles each digit stays lit (>= 2)
//   BLINK_FRAMES  full frames per blink half-period (>= 1)
// Ports:
//   CLK        system clock, rising edge
//   CLR        asynchronous active-low reset
//   CE         enable; low freezes all state and blanks the display
//   sec_units, sec_tens, min_units, min_tens  BCD digits from the timer
//   OVERFLOW   timer expired flag
//   SEG        active-low segments {g,f,e,d,c,b,a}
//   DP         active-low decimal point
//   AN         active-low anodes, AN[0] = rightmost digit
module clock_display_scanner
  import clock_display_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic [3:0] sec_units,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_units,
  input  logic [3:0] min_tens,
  input  logic       OVERFLOW,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]   divCnt_q, divCnt_d;
  digitIdx_e          idx_q, idx_d;
  logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;
  logic               phase_q, phase_d;
  shadow_t            shadow_q, shadow_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               dp_q, dp_d;

  logic               divTerm;
  logic               frameEdge;
  logic               blinkWrap;
  logic [3:0]         curDigit;
  logic [6:0]         rawSeg;

  // Event strobes; all are gated by CE so a frozen scanner never advances
  assign divTerm   = CE && (divCnt_q == DIV_LAST);
  assign frameEdge = divTerm && (idx_q == IDX_MT);
  assign blinkWrap = frameEdge && (frameCnt_q == FRAME_LAST);

  // Next state of the prescaler, scan index, blink counters and shadows.
  // The snapshot and any phase toggle share the frame-boundary edge so
  // they always take effect together.
  always_comb begin
    divCnt_d   = divCnt_q;
    idx_d      = idx_q;
    frameCnt_d = frameCnt_q;
    phase_d    = phase_q;
    shadow_d   = shadow_q;
    if (CE) begin
      divCnt_d = divTerm ? '0 : divCnt_q + DIV_W'(1);
    end
    if (divTerm) begin
      idx_d = nextIdx(idx_q);
    end
    if (frameEdge) begin
      shadow_d   = '{minTens:  min_tens,  minUnits: min_units,
                     secTens:  sec_tens,  secUnits: sec_units,
                     overflow: OVERFLOW};
      frameCnt_d = blinkWrap ? '0 : frameCnt_q + FRAME_W'(1);
    end
    if (blinkWrap) begin
      phase_d = ~phase_q;
    end
  end

  // Pick the shadowed digit for the position currently being scanned
  always_comb begin
    curDigit = 4'd0;
    case (idx_q)
      IDX_SU:  curDigit = shadow_q.secUnits;
      IDX_ST:  curDigit = shadow_q.secTens;
      IDX_MU:  curDigit = shadow_q.minUnits;
      default: curDigit = shadow_q.minTens;
    endcase
  end

  bcd_to_seg uDecode (
    .bcd_i (curDigit),
    .seg_o (rawSeg)
  );

  // Output pattern for the next cycle. Blanking priority: disabled, then
  // overflow off-phase, then the leading minutes-tens zero. The anodes
  // keep scanning while only the segments are blanked.
  always_comb begin
    seg_d = rawSeg;
    an_d  = anodeFor(idx_q);
    dp_d  = 1'b1;
    if (!CE) begin
      seg_d = SEG_BLANK;
      an_d  = 4'b1111;
    end else if (shadow_q.overflow && !phase_q) begin
      seg_d = SEG_BLANK;
    end else if ((idx_q == IDX_MT) && (shadow_q.minTens == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
    if (CE && (idx_q == IDX_MU) && (shadow_q.overflow || phase_q)) begin
      dp_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      divCnt_q   <= '0;
      idx_q      <= IDX_SU;
      frameCnt_q <= '0;
      phase_q    <= 1'b0;
      shadow_q   <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'b1111;
      dp_q       <= 1'b1;
    end else begin
      divCnt_q   <= divCnt_d;
      idx_q      <= idx_d;
      frameCnt_q <= frameCnt_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign DP  = dp_q;

endmodule
